// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame geometry, command bytes.
// No logic; the parity helper is pure combinational.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        XFER,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-flop synchronizer for a raw PS/2 pin plus falling-edge strobe.
// Latency: sync 2 clk, fe valid on the first cycle sync reads 0; no backpressure.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic fe
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle (pulled-up) line level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign fe   = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 10 bits, ack).
// Latency: INHIBIT_CYC + 1 + device-clocked frame; tx_ready only in IDLE, extra tx_valid ignored.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_nack,
    output logic       tx_timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX   = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int SHIFT_LEN = FRAME_LEN - 1;
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);

    ps2_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [SHIFT_LEN-1:0] frame_q, frame_d;
    logic                 dat_q, dat_d;
    logic                 nack_q, nack_d;

    logic clk_s, clk_fe, dat_s, data_fe_unused;

    ps2_sync_edge u_sync_clk (
        .clk  (clk),
        .rst  (rst),
        .din  (ps2_clk_in),
        .sync (clk_s),
        .fe   (clk_fe)
    );

    ps2_sync_edge u_sync_data (
        .clk  (clk),
        .rst  (rst),
        .din  (ps2_data_in),
        .sync (dat_s),
        .fe   (data_fe_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '1;
            dat_q   <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            dat_q   <= dat_d;
            nack_q  <= nack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        dat_d      = dat_q;
        nack_d     = nack_q;
        tx_done    = 1'b0;
        tx_nack    = 1'b0;
        tx_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    frame_d = {1'b1, odd_parity(tx_data), tx_data};
                    cnt_d   = '0;
                    nack_d  = 1'b0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) state_d = START;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            START: begin
                state_d = XFER;
                cnt_d   = '0;
                bit_d   = '0;
                dat_d   = 1'b1;
            end
            XFER: begin
                // Each device falling edge shifts out the next frame bit.
                if (clk_fe) begin
                    dat_d   = ~frame_q[0];
                    frame_d = {1'b1, frame_q[SHIFT_LEN-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd9) state_d = ACK;
                end
            end
            ACK: begin
                if (clk_fe) begin
                    nack_d  = dat_s;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    tx_done = 1'b1;
                    tx_nack = nack_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stall watchdog; it overrides any completion seen in the same cycle.
        if (state_q == XFER || state_q == ACK || state_q == WAIT_IDLE) begin
            if (cnt_q == TO_LIMIT) begin
                tx_done    = 1'b1;
                tx_nack    = 1'b0;
                tx_timeout = 1'b1;
                state_d    = IDLE;
            end else if (clk_fe) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign tx_busy     = (state_q != IDLE);
    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == START);
    assign ps2_data_oe = (state_q == START) || ((state_q == XFER) && dat_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares every line level and handshake against frames built from the byte.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 5000;
    localparam int TO   = 100;
    localparam int HALF = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_done, tx_nack, tx_timeout;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_lo, dev_dat_lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Open-drain bus: either side may pull a line low.
    assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_lo);
    assign ps2_data_in = ~(ps2_data_oe | dev_dat_lo);

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_nack     (tx_nack),
        .tx_timeout  (tx_timeout),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode: 0 device acks, 1 device nacks, 2 device never clocks, 3 reset after fe 4
    task automatic send(input logic [7:0] d, input int mode, input bit hold);
        logic [9:0] fr;
        int         ones;
        int         k;
        string      id;
        id   = $sformatf("%02h", d);
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        fr = {1'b1, ((ones % 2) == 0), d};

        k = 0;
        while (!tx_ready && k < 1000) begin @(negedge clk); k++; end
        chk({"ready_", id}, tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        chk({"busy_", id}, tx_busy, 1);
        chk({"ready_low_", id}, tx_ready, 0);
        if (hold) begin
            tx_data = 8'hAA;
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end

        k = 0;
        while (ps2_clk_oe && !ps2_data_oe && k < INH + 10) begin @(negedge clk); k++; end
        chk({"inhibit_len_", id}, k, INH);
        k = 0;
        while (ps2_clk_oe && ps2_data_oe && k < 10) begin @(negedge clk); k++; end
        chk({"start_len_", id}, k, 1);
        chk({"xfer_clk_oe_", id}, ps2_clk_oe, 0);
        chk({"xfer_start_bit_", id}, ps2_data_oe, 1);

        if (mode == 2) begin
            k = 0;
            while (!tx_done && k < TO + 50) begin @(negedge clk); k++; end
            chk("timeout_cycles", k, TO);
            chk("timeout_flag", tx_timeout, 1);
            chk("timeout_nack", tx_nack, 0);
            @(negedge clk);
            chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
            chk("timeout_ready", tx_ready, 1);
            chk("timeout_flags_clear", {tx_done, tx_nack, tx_timeout}, 0);
            return;
        end

        for (int n = 1; n <= 11; n++) begin
            repeat (HALF) @(negedge clk);
            if (n == 11) begin
                dev_dat_lo = (mode == 0);
                repeat (4) @(negedge clk);
            end
            dev_clk_lo = 1'b1;
            repeat (HALF) @(negedge clk);
            if (n <= 10) chk($sformatf("bit%0d_%s", n, id), ps2_data_in, fr[n-1]);
            if (n == 10) chk({"ack_release_", id}, {ps2_clk_oe, ps2_data_oe}, 0);
            if (mode == 3 && n == 4) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
                chk("rst_ready", tx_ready, 1);
                chk("rst_busy", tx_busy, 0);
                chk("rst_done", tx_done, 0);
                rst        = 1'b0;
                dev_clk_lo = 1'b0;
                k = 0;
                repeat (200) begin
                    @(negedge clk);
                    if (tx_done || !tx_ready) k++;
                end
                chk("rst_no_done", k, 0);
                return;
            end
            dev_clk_lo = 1'b0;
        end

        k = 0;
        while (!tx_done && k < HALF + 60) begin
            @(negedge clk);
            k++;
            if (k == HALF) dev_dat_lo = 1'b0;
        end
        chk({"done_", id}, tx_done, 1);
        chk({"nack_", id}, tx_nack, (mode == 1));
        chk({"tout_", id}, tx_timeout, 0);
        chk({"ready_at_done_", id}, tx_ready, 0);
        @(negedge clk);
        chk({"ready_after_", id}, tx_ready, 1);
        chk({"flags_clear_", id}, {tx_done, tx_nack, tx_timeout}, 0);
    endtask

    initial begin
        int k;
        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        dev_clk_lo = 1'b0;
        dev_dat_lo = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", tx_ready, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("reset_flags", {tx_done, tx_nack, tx_timeout}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", tx_ready, 1);

        send(CMD_SET_LEDS, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        send(8'h01, 0, 1'b0);
        send(8'hFF, 0, 1'b0);
        send(8'h80, 0, 1'b0);
        send(8'($urandom), 1, 1'b0);
        send(8'h5A, 2, 1'b0);
        send(CMD_RESET, 3, 1'b0);
        send(8'hF4, 0, 1'b0);

        // tx_valid held with 8'hAA through a busy transfer: exactly one extra frame.
        send(CMD_SET_LEDS, 0, 1'b1);
        send(8'hAA, 0, 1'b0);
        k = 0;
        repeat (50) begin
            @(negedge clk);
            if (ps2_clk_oe || !tx_ready) k++;
        end
        chk("no_extra_xfer", k, 0);

        send(8'($urandom), int'($urandom_range(0, 1)), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 5000: number of clk cycles ps2_clk is held low before the request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 1_000_000: maximum clk cycles allowed between device clock falling edges, or while waiting for idle (20 ms at 50 MHz).
REQ-003 clk  in  1  system clock; the block has one clock, and all logic is on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 tx_data  in  8  command byte to send to the keyboard (for example 8'hED, set LEDs).
REQ-006 tx_valid  in  1  request to send; qualifies tx_data.
REQ-007 tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high.
REQ-008 tx_busy  out  1  high in every state except IDLE; the PS/2 receiver uses it to ignore frames.
REQ-009 tx_done  out  1  one-cycle pulse that ends every accepted transfer.
REQ-010 tx_nack  out  1  valid with tx_done: acknowledge bit was missing.
REQ-011 tx_timeout  out  1  valid with tx_done: the device stalled.
REQ-012 ps2_clk_in, ps2_data_in  in  1 each  raw, asynchronous PS/2 pin levels.
REQ-013 ps2_clk_oe, ps2_data_oe  out  1 each  open-drain pull-low enables; 1 drives the line low.

Function
REQ-014 Both PS/2 inputs SHALL pass through a 2-flop synchronizer; a device clock falling edge ("fe") is synced clk 1 -> 0, detected one cycle later.
REQ-015 States: IDLE, INHIBIT, START, XFER, ACK, WAIT_IDLE.
REQ-016 IDLE: both oe = 0.
- On accept: latch tx_data.
- Frame shift register = {stop 1, parity ~^tx_data, tx_data}.
- Next state INHIBIT, counter = 0.
REQ-017 INHIBIT: clk_oe = 1, data_oe = 0 for exactly INHIBIT_CYC cycles, then START.
REQ-018 START: clk_oe = 1, data_oe = 1 for exactly 1 cycle (start bit 0), then XFER with clk_oe = 0 and data_oe still 1.
REQ-019 XFER: on fe number n (n = 1..10), the cycle after detection data_oe = ~frame[n-1]. Order: d0..d7, then odd parity, then stop (data_oe = 0).
REQ-020 After fe 10, the state becomes ACK with both oe = 0.
REQ-021 ACK: on fe 11, sample synced data; 0 = acknowledged, 1 = nack latched. Next state WAIT_IDLE.
REQ-022 WAIT_IDLE: when synced clk and data are both 1, pulse tx_done (with tx_nack as latched) and return to IDLE.
REQ-023 Timeout counter: cleared on entering XFER and on every fe; counts in XFER, ACK and WAIT_IDLE.
REQ-024 When the timeout counter reaches TIMEOUT_CYC: both oe = 0 next cycle, pulse tx_done with tx_timeout = 1 and tx_nack = 0, return to IDLE.
REQ-025 tx_valid while not in IDLE SHALL be ignored, with no queueing; tx_data changes after accept SHALL have no effect.
REQ-026 An fe in IDLE, INHIBIT or START SHALL be ignored.
REQ-027 tx_ready SHALL re-assert the cycle after tx_done, so back-to-back transfers are possible.
REQ-028 tx_nack and tx_timeout SHALL be 0 whenever tx_done = 0.

Reset
REQ-029 With rst high at a clock edge, the next cycle SHALL have: state IDLE, every oe = 0, tx_ready = 1, tx_busy = 0, tx_done, tx_nack, tx_timeout = 0, counters and synchronizers cleared to 1 (idle line level).
REQ-030 Reset mid-transfer SHALL release both lines within one cycle, with no tx_done pulse.

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum, frame length 11, and PS/2 command constants (8'hED set LEDs, 8'hFF reset, 8'hFA ack).
REQ-032 Sub-module ps2_sync_edge (2-flop synchronizer plus falling-edge detect) SHALL be instantiated once each for clk and data, and be shared with the receiver.

Verification
REQ-033 Send 8'hED with a device model that acknowledges:
- clk_oe low for 5000 cycles, then a 1-cycle start.
- Data bits 1,0,1,1,0,1,1,1, then parity 1, then stop released.
- Ack 0 -> tx_done = 1, tx_nack = 0.
REQ-034 Parity sweep: 8'h00 -> parity 1; 8'h01 -> parity 0; 8'hFF -> parity 1; 8'h80 -> parity 0.
REQ-035 Device holds data high at fe 11 -> tx_done = 1, tx_nack = 1, back to IDLE after the lines are idle.
REQ-036 Device never clocks after START (TIMEOUT_CYC = 100 in the bench) -> tx_done with tx_timeout = 1, 100 cycles after XFER entry, both oe = 0.
REQ-037 rst pulsed after fe 4 of byte 8'hFF -> next cycle both oe = 0, tx_ready = 1, no tx_done; a following 8'hF4 transfer completes normally.
REQ-038 tx_valid held high with data 8'hAA during a busy transfer -> not accepted until the cycle after tx_done, then exactly one further transfer occurs.
